pipelined_addsub_module: RTL and testbench
==========================================

Name: pipelined_addsub_module

Overview:
- Parametrised N-bit adder/subtractor. Carry chain is split into CHUNK-bit slices, with one register stage per slice.
- Valid/ready handshake on input and output; full throughput of one result per cycle; backpressure stalls the whole pipeline.
- Successor to the 4-bit ripple adder. Sits in the datapath wherever WIDTH-bit sums must meet timing at clk rate.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits resolved per pipeline stage.
STAGES, WIDTH/CHUNK (derived localparam), pipeline depth = latency in cycles.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands present on a, b, cin, sub.
in_ready  output  1  block can accept operands this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in; used only when sub=0.
sub  input  1  0: a+b+cin; 1: a-b.
out_valid  output  1  result present.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  result.
cout  output  1  carry-out of bit WIDTH-1; for sub, 1 = no borrow.
ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: all stage valid bits = 0; out_valid = 0; sum = 0; cout = 0; ovf = 0. in_ready = 1 once out of reset.
- Reset mid-operation: all in-flight items are discarded; no partial result ever appears.
- Input transfer: occurs when in_valid & in_ready. Output transfer: occurs when out_valid & out_ready.
- Stage k (0..STAGES-1) holds: a valid bit, result bits [k*CHUNK+CHUNK-1:0], the slice carry, and the unprocessed upper operand bits. It also holds the sub flag and the operand MSBs needed for ovf.
- Subtract: b is inverted at the input, and carry-in is forced to 1. cin is ignored when sub=1.
- Stage k adds slice k using the carry registered by stage k-1. Stage 0 uses cin, or 1 when sub=1.
- Final stage: drives sum, cout, and ovf = (a[MSB] ~^ b'[MSB]) & (sum[MSB] ^ a[MSB]), where b' is the post-inversion b.
- Latency: an item accepted in cycle t appears with out_valid=1 in cycle t+STAGES, provided there is no backpressure.
- Stage advance rule: stage k advances when its successor is empty or advancing. The last stage advances when out_ready is high or it is empty.
- in_ready = !stage0_valid | stage0_advances. This is a combinational chain from out_ready; there is no bubble insertion.
- Stall: outputs hold stable while out_valid & !out_ready. No item is dropped or duplicated.
- Simultaneous accept and emit with a full pipeline: legal; throughput is sustained at 1 per cycle.
- Wrap-around: sum is modulo 2^WIDTH. Carry beyond the MSB goes to cout only.
- CHUNK == WIDTH: single-stage, latency 1.
- A WIDTH not divisible by CHUNK is an elaboration error.

Optional Feature:
- Macro SATURATE_EN.
- When defined: on ovf=1, sum is replaced by the signed limit in the last stage. The limit is 0x7FFF.. if a[MSB]=0, otherwise 0x8000... ovf is still reported, and cout is unchanged. Latency and handshake are unchanged.
- When undefined: sum is always the wrapped result.

Test Plan:
All scenarios use WIDTH=16, CHUNK=4.
1. Reset: assert rst_n=0 mid-stream with 3 items in flight, then release -> out_valid=0, sum=0; no stale item appears; in_ready=1.
2. Add: a=0x1234, b=0x0FFF, cin=1, sub=0, out_ready=1 -> 4 cycles later sum=0x2234, cout=0, ovf=0.
3. Sub and wrap: a=0x0000, b=0x0001, sub=1 -> sum=0xFFFF, cout=0 (borrow), ovf=0. Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1 (0x8000 under SATURATE_EN).
4. Overflow: a=0x7FFF, b=0x0001, sub=0, cin=0 -> sum=0x8000, ovf=1, cout=0. With SATURATE_EN: sum=0x7FFF.
5. Backpressure: stream 10 back-to-back items, hold out_ready=0 for 6 cycles from cycle 5 -> in_ready drops once 4 items are held. Outputs stay stable; all 10 results emerge in order with none lost or duplicated.
6. Full throughput: 100 random items with in_valid=1 and out_ready=1 constantly -> one result per cycle after 4-cycle fill; each matches reference a±b.

Source files
------------

// File: rtl/pipelined_addsub_module.sv
// Pipelined WIDTH-bit adder/subtractor resolving CHUNK bits per register stage, with valid/ready flow control.
// Optional macro SATURATE_EN clamps overflowing results to the signed limit selected by a[MSB].
module pipelined_addsub_module #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int STAGES = WIDTH / CHUNK;
   localparam int MSB    = WIDTH - 1;

   if ((WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("pipelined_addsub_module: WIDTH must be a multiple of CHUNK");
   end

`ifdef SATURATE_EN
   // Positive overflow clamps to 0x7F..F, negative overflow to 0x80..0.
   function automatic logic signed [WIDTH-1:0] sat_limit(input logic neg);
      logic signed [WIDTH-1:0] lim;
      lim = {neg, {(WIDTH-1){~neg}}};
      return lim;
   endfunction
`endif

   logic [STAGES-1:0] vld_q, vld_d;
   logic [STAGES-1:0] carry_q, carry_d;
   logic [STAGES-1:0] adv;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  res_q [STAGES];
   logic [WIDTH-1:0]  res_d [STAGES];
   logic              ovf_q, ovf_d;

   // A stage moves when any stage at or after it is empty, or the output is being taken.
   always_comb begin : advance
      logic empty_seen;
      adv = '0;
      for (int k = 0; k < STAGES; k++) begin
         empty_seen = 1'b0;
         for (int j = k; j < STAGES; j++) begin
            empty_seen = empty_seen | ~vld_q[j];
         end
         adv[k] = out_ready | empty_seen;
      end
   end

   assign in_ready = adv[0];

   always_comb begin : datapath
      logic [WIDTH-1:0] src_a, src_b, src_res, full_res;
      logic             src_c;
      logic [CHUNK:0]   slice;
      int               p;
      vld_d   = '0;
      carry_d = '0;
      ovf_d   = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         p = (k > 0) ? k - 1 : 0;
         // Stage 0 boundary: operands straight from the ports, b inverted and carry forced for subtract
         if (k == 0) begin
            src_a    = a;
            src_b    = sub ? ~b : b;
            src_c    = sub | cin;
            src_res  = '0;
            vld_d[k] = in_valid;
         end else begin
            src_a    = a_q[p];
            src_b    = b_q[p];
            src_c    = carry_q[p];
            src_res  = res_q[p];
            vld_d[k] = vld_q[p];
         end
         slice = {1'b0, src_a[k*CHUNK +: CHUNK]} + {1'b0, src_b[k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, src_c};
         full_res = src_res;
         full_res[k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
         a_d[k]     = src_a;
         b_d[k]     = src_b;
         carry_d[k] = slice[CHUNK];
         res_d[k]   = full_res;
         // Final stage boundary: overflow from operand and result sign bits
         if (k == STAGES - 1) begin
            ovf_d = (src_a[MSB] ~^ src_b[MSB]) & (full_res[MSB] ^ src_a[MSB]);
`ifdef SATURATE_EN
            if (ovf_d) begin
               res_d[k] = sat_limit(src_a[MSB]);
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q   <= '0;
         carry_q <= '0;
         ovf_q   <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            res_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
               vld_q[k]   <= vld_d[k];
               carry_q[k] <= carry_d[k];
               a_q[k]     <= a_d[k];
               b_q[k]     <= b_d[k];
               res_q[k]   <= res_d[k];
            end
         end
         if (adv[STAGES-1]) begin
            ovf_q <= ovf_d;
         end
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign sum       = res_q[STAGES-1];
   assign cout      = carry_q[STAGES-1];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub_module.sv
// Scoreboard bench for pipelined_addsub_module (WIDTH=16, CHUNK=4): directed table, reset, latency, backpressure, throughput.
module tb_pipelined_addsub_module;
   localparam int WIDTH  = 16;
   localparam int CHUNK  = 4;
   localparam int STAGES = WIDTH / CHUNK;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   typedef struct packed {
      logic [15:0] s;
      logic        co;
      logic        ov;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a_i, b_i, sum;
   logic        cin_i, sub_i, cout, ovf;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_out    = 0;
   res_t exp_q[$];
   res_t hold;
   logic hold_vld = 1'b0;

   pipelined_addsub_module #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub);
      res_t        r;
      logic [16:0] t;
      int          sr;
      if (sub) begin
         t    = {1'b0, a} - {1'b0, b};
         r.co = (a >= b);
         sr   = int'($signed(a)) - int'($signed(b));
      end else begin
         t    = {1'b0, a} + {1'b0, b} + {16'd0, cin};
         r.co = t[16];
         sr   = int'($signed(a)) + int'($signed(b)) + int'(cin);
      end
      r.s  = t[15:0];
      r.ov = (sr > 32767) || (sr < -32768);
`ifdef SATURATE_EN
      if (r.ov) r.s = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
      return r;
   endfunction

   function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic cin,
                               input logic sub, input logic [15:0] s, input logic co, input logic ov);
      vec_t v;
      v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.s = s; v.co = co; v.ov = ov;
      return v;
   endfunction

   // Drive one item, hold it until accepted, record its expected result at acceptance.
   task automatic send(input vec_t v, output int stalls);
      res_t e;
      stalls   = 0;
      a_i      = v.a;
      b_i      = v.b;
      cin_i    = v.cin;
      sub_i    = v.sub;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      check("send_accepted", 32'(in_ready), 32'd1);
      if (in_ready) begin
         e.s = v.s; e.co = v.co; e.ov = v.ov;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 200) begin
         @(posedge clk);
         #2;
         g++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Output monitor: scoreboard compare on transfer, stability check while stalled.
   always @(negedge clk) begin
      res_t e;
      if (!rst_n) begin
         hold_vld = 1'b0;
      end else begin
         if (hold_vld) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_sum", 32'(sum), 32'(hold.s));
            check("stall_cout", 32'(cout), 32'(hold.co));
            check("stall_ovf", 32'(ovf), 32'(hold.ov));
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: actual sum=%h, required no output", sum);
            end else begin
               e = exp_q.pop_front();
               check("sum", 32'(sum), 32'(e.s));
               check("cout", 32'(cout), 32'(e.co));
               check("ovf", 32'(ovf), 32'(e.ov));
            end
         end
         hold_vld = out_valid && !out_ready;
         hold.s   = sum;
         hold.co  = cout;
         hold.ov  = ovf;
      end
   end

`ifdef SATURATE_EN
   localparam logic [15:0] S_8000_M1 = 16'h8000;
   localparam logic [15:0] S_7FFF_P1 = 16'h7FFF;
   localparam logic [15:0] S_8000_P8 = 16'h8000;
   localparam logic [15:0] S_7FFF_MN = 16'h7FFF;
`else
   localparam logic [15:0] S_8000_M1 = 16'h7FFF;
   localparam logic [15:0] S_7FFF_P1 = 16'h8000;
   localparam logic [15:0] S_8000_P8 = 16'h0000;
   localparam logic [15:0] S_7FFF_MN = 16'h8000;
`endif

   vec_t dir_tab[10];
   vec_t rnd_tab[100];

   initial begin
      int st, lat, cnt, out0, stall_sum, c0, cyc;
      logic saw_block;
      res_t e;

      dir_tab[0] = mk(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
      dir_tab[1] = mk(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      dir_tab[2] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, S_8000_M1, 1'b1, 1'b1);
      dir_tab[3] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, S_7FFF_P1, 1'b0, 1'b1);
      dir_tab[4] = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      dir_tab[5] = mk(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
      dir_tab[6] = mk(16'h8000, 16'h8000, 1'b0, 1'b0, S_8000_P8, 1'b1, 1'b1);
      dir_tab[7] = mk(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, S_7FFF_MN, 1'b0, 1'b1);
      dir_tab[8] = mk(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
      dir_tab[9] = mk(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      for (int i = 0; i < 100; i++) begin
         rnd_tab[i].a   = 16'($urandom());
         rnd_tab[i].b   = 16'($urandom());
         rnd_tab[i].cin = 1'($urandom());
         rnd_tab[i].sub = 1'($urandom());
         e = model(rnd_tab[i].a, rnd_tab[i].b, rnd_tab[i].cin, rnd_tab[i].sub);
         rnd_tab[i].s  = e.s;
         rnd_tab[i].co = e.co;
         rnd_tab[i].ov = e.ov;
      end

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Latency of a lone item with no backpressure.
      a_i = dir_tab[0].a; b_i = dir_tab[0].b; cin_i = dir_tab[0].cin; sub_i = dir_tab[0].sub;
      in_valid = 1'b1;
      @(negedge clk);
      check("lat_in_ready", 32'(in_ready), 32'd1);
      e.s = dir_tab[0].s; e.co = dir_tab[0].co; e.ov = dir_tab[0].ov;
      exp_q.push_back(e);
      @(posedge clk);
      lat = 1;
      #1;
      in_valid = 1'b0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(STAGES));
      drain();

      // Directed table, back-to-back.
      for (int i = 0; i < 10; i++) begin
         send(dir_tab[i], st);
      end
      drain();

      // Reset with three items in flight: none may surface afterwards.
      for (int i = 0; i < 3; i++) begin
         send(rnd_tab[i], st);
      end
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_sum", 32'(sum), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("midrst_no_stale", 32'(cnt), 32'd0);
      @(posedge clk);
      #1;

      // Backpressure: 10 items streamed, out_ready low for 6 cycles starting at cycle 5.
      out0 = n_out;
      saw_block = 1'b0;
      fork
         begin
            int s1;
            for (int i = 0; i < 10; i++) send(rnd_tab[i], s1);
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (6) begin
               @(negedge clk);
               if (!in_ready) saw_block = 1'b1;
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_in_ready_dropped", 32'(saw_block), 32'd1);
      check("bp_count", 32'(n_out - out0), 32'd10);

      // Full throughput: 100 items, one accepted and one emitted per cycle.
      out0 = n_out;
      stall_sum = 0;
      cyc = 0;
      c0 = $time / 10;
      for (int i = 0; i < 100; i++) begin
         send(rnd_tab[i], st);
         stall_sum += st;
      end
      drain();
      cyc = ($time / 10) - c0;
      check("tp_stalls", 32'(stall_sum), 32'd0);
      check("tp_count", 32'(n_out - out0), 32'd100);
      check("tp_cycles", 32'(cyc), 32'(100 + STAGES));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
